// File: rtl/gcd_operand_loader.sv
// Switch/button front-end for the GCD core: digit-serial operand entry, operand
// streaming with a load strobe, and result digit display. Optional core watchdog: GCD_WAIT_TIMEOUT_EN.
module gcd_operand_loader #(
    parameter int DATA_W      = 8,
    parameter int DIG_W       = 4,
    parameter int N_OPS       = 2,
    parameter int TIMEOUT_CYC = 1024,
    localparam int NDIG       = DATA_W / DIG_W,
    localparam int SEL_W      = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DIG_W-1:0]  switches,
    input  logic [SEL_W-1:0]  sel,
    output logic              core_load,
    output logic [DATA_W-1:0] core_data,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic [DIG_W-1:0]  leds,
    output logic              busy,
    output logic              shown,
    output logic              err
);

    localparam int OP_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [SEL_W-1:0] LAST_DIG = SEL_W'(NDIG - 1);
    localparam logic [OP_W-1:0]  LAST_OP  = OP_W'(N_OPS - 1);

    if ((NDIG * DIG_W != DATA_W) || (N_OPS < 1) || (TIMEOUT_CYC < 1)) begin : g_cfg_bad
        $error("gcd_operand_loader: invalid parameter set");
    end

    typedef enum logic [2:0] {
        ST_ENTER     = 3'd0,
        ST_SEND_LOAD = 3'd1,
        ST_SEND_DATA = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_SHOW      = 3'd4
    } state_t;

    state_t                         state_r, state_nx_s;
    logic [SEL_W-1:0]               dig_idx_r, dig_idx_nx_s, dig_pos_s;
    logic [OP_W-1:0]                op_idx_r, op_idx_nx_s;
    logic [OP_W-1:0]                k_r, k_nx_s;
    logic [N_OPS-1:0][DATA_W-1:0]   ops_r, ops_nx_s;
    logic [DATA_W-1:0]              result_r, res_nx_s;
    logic                           wr_dig_s, clr_ops_s, latch_res_s, tmo_hit_s;

    logic                           core_load_r, core_load_nx_s;
    logic [DATA_W-1:0]              core_data_r, core_data_nx_s;
    logic [DIG_W-1:0]               leds_r, leds_nx_s, dig_mux_s;
    logic                           busy_r, busy_nx_s;
    logic                           shown_r, shown_nx_s;
    logic                           err_r, err_nx_s;

    // Digits arrive MSB first, so entry index 0 lands in the top digit.
    assign dig_pos_s = LAST_DIG - dig_idx_r;

`ifdef GCD_WAIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_r;

    // Watchdog counter: runs only while waiting for the core, zero otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if (state_r != ST_WAIT_DONE) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
        end
    end

    assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state, index and datapath-control decode.
    always_comb begin
        state_nx_s   = state_r;
        dig_idx_nx_s = dig_idx_r;
        op_idx_nx_s  = op_idx_r;
        k_nx_s       = k_r;
        wr_dig_s     = 1'b0;
        clr_ops_s    = 1'b0;
        latch_res_s  = 1'b0;
        err_nx_s     = err_r;
        case (state_r)
            ST_ENTER: begin
                if (load) begin
                    wr_dig_s = 1'b1;
                    if (dig_idx_r == LAST_DIG) begin
                        dig_idx_nx_s = '0;
                        if (op_idx_r == LAST_OP) begin
                            op_idx_nx_s = '0;
                            state_nx_s  = ST_SEND_LOAD;
                        end else begin
                            op_idx_nx_s = op_idx_r + 1'b1;
                        end
                    end else begin
                        dig_idx_nx_s = dig_idx_r + 1'b1;
                    end
                end else begin
                    state_nx_s = ST_ENTER;
                end
            end
            ST_SEND_LOAD: begin
                state_nx_s = ST_SEND_DATA;
                k_nx_s     = '0;
            end
            ST_SEND_DATA: begin
                if (k_r == LAST_OP) begin
                    state_nx_s = ST_WAIT_DONE;
                end else begin
                    k_nx_s = k_r + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (core_done) begin
                    latch_res_s = 1'b1;
                    state_nx_s  = ST_SHOW;
                end else if (tmo_hit_s) begin
                    err_nx_s   = 1'b1;
                    state_nx_s = ST_SHOW;
                end else begin
                    state_nx_s = ST_WAIT_DONE;
                end
            end
            ST_SHOW: begin
                if (load) begin
                    clr_ops_s    = 1'b1;
                    dig_idx_nx_s = '0;
                    op_idx_nx_s  = '0;
                    err_nx_s     = 1'b0;
                    state_nx_s   = ST_ENTER;
                end else begin
                    state_nx_s = ST_SHOW;
                end
            end
            default: begin
                state_nx_s = ST_ENTER;
            end
        endcase
    end

    // Operand register update: one digit slot written per entry pulse.
    always_comb begin
        ops_nx_s = ops_r;
        for (int o = 0; o < N_OPS; o++) begin
            for (int d = 0; d < NDIG; d++) begin
                ops_nx_s[o][d*DIG_W +: DIG_W] =
                    clr_ops_s ? {DIG_W{1'b0}} :
                    (wr_dig_s && (op_idx_r == OP_W'(o)) && (dig_pos_s == SEL_W'(d))) ? switches :
                    ops_r[o][d*DIG_W +: DIG_W];
            end
        end
    end

    // Registered-output lookahead: outputs follow the state being entered.
    always_comb begin
        res_nx_s       = latch_res_s ? core_result : result_r;
        core_data_nx_s = '0;
        dig_mux_s      = '0;
        for (int o = 0; o < N_OPS; o++) begin
            core_data_nx_s = core_data_nx_s | ({DATA_W{k_nx_s == OP_W'(o)}} & ops_r[o]);
        end
        if (state_nx_s != ST_SEND_DATA) begin
            core_data_nx_s = core_data_r;
        end else begin
            core_data_nx_s = core_data_nx_s;
        end
        // Unmatched select codes (sel >= NDIG) leave the mux at zero.
        for (int d = 0; d < NDIG; d++) begin
            dig_mux_s = dig_mux_s | ({DIG_W{sel == SEL_W'(d)}} & res_nx_s[d*DIG_W +: DIG_W]);
        end
        if (state_nx_s == ST_SHOW) begin
            if (err_nx_s) begin
                leds_nx_s = '1;
            end else begin
                leds_nx_s = dig_mux_s;
            end
        end else begin
            leds_nx_s = '0;
        end
        core_load_nx_s = (state_nx_s == ST_SEND_LOAD);
        busy_nx_s      = (state_nx_s == ST_SEND_LOAD) || (state_nx_s == ST_SEND_DATA) ||
                         (state_nx_s == ST_WAIT_DONE);
        shown_nx_s     = (state_nx_s == ST_SHOW);
    end

    // FSM state, indices, operand and result storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_ENTER;
            dig_idx_r <= '0;
            op_idx_r  <= '0;
            k_r       <= '0;
            ops_r     <= '0;
            result_r  <= '0;
        end else begin
            state_r   <= state_nx_s;
            dig_idx_r <= dig_idx_nx_s;
            op_idx_r  <= op_idx_nx_s;
            k_r       <= k_nx_s;
            ops_r     <= ops_nx_s;
            result_r  <= res_nx_s;
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_load_r <= 1'b0;
            core_data_r <= '0;
            leds_r      <= '0;
            busy_r      <= 1'b0;
            shown_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            core_load_r <= core_load_nx_s;
            core_data_r <= core_data_nx_s;
            leds_r      <= leds_nx_s;
            busy_r      <= busy_nx_s;
            shown_r     <= shown_nx_s;
            err_r       <= err_nx_s;
        end
    end

    assign core_load = core_load_r;
    assign core_data = core_data_r;
    assign leds      = leds_r;
    assign busy      = busy_r;
    assign shown     = shown_r;
    assign err       = err_r;

endmodule

// File: tb/tb_gcd_operand_loader.sv
// Scoreboard bench for gcd_operand_loader: a default 8-bit/2-operand instance and
// a 12-bit/3-operand instance share stimulus; expected operands are queued at entry.
`timescale 1ns/1ps
module tb_gcd_operand_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, load, use_b, core_done;
    logic [3:0]  switches;
    logic [1:0]  sel;
    logic [7:0]  res_a;
    logic [11:0] res_b;
    logic        load_a, load_b;

    logic        cl_a, busy_a, shown_a, err_a;
    logic [7:0]  cd_a;
    logic [3:0]  leds_a;
    logic        cl_b, busy_b, shown_b, err_b;
    logic [11:0] cd_b;
    logic [3:0]  leds_b;

    logic        mon_cl, mon_busy, mon_shown, mon_err;
    logic [15:0] mon_cd;
    logic [3:0]  mon_leds;

    assign load_a    = load & ~use_b;
    assign load_b    = load & use_b;
    assign mon_cl    = use_b ? cl_b : cl_a;
    assign mon_busy  = use_b ? busy_b : busy_a;
    assign mon_shown = use_b ? shown_b : shown_a;
    assign mon_err   = use_b ? err_b : err_a;
    assign mon_cd    = use_b ? {4'h0, cd_b} : {8'h00, cd_a};
    assign mon_leds  = use_b ? leds_b : leds_a;

    gcd_operand_loader #(.DATA_W(8), .DIG_W(4), .N_OPS(2), .TIMEOUT_CYC(16)) dut_a (
        .clock(clock), .reset(reset), .load(load_a), .switches(switches), .sel(sel[0]),
        .core_load(cl_a), .core_data(cd_a), .core_done(core_done), .core_result(res_a),
        .leds(leds_a), .busy(busy_a), .shown(shown_a), .err(err_a)
    );

    gcd_operand_loader #(.DATA_W(12), .DIG_W(4), .N_OPS(3), .TIMEOUT_CYC(16)) dut_b (
        .clock(clock), .reset(reset), .load(load_b), .switches(switches), .sel(sel),
        .core_load(cl_b), .core_data(cd_b), .core_done(core_done), .core_result(res_b),
        .leds(leds_b), .busy(busy_b), .shown(shown_b), .err(err_b)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    logic [3:0]  dq[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_load(input logic [3:0] d);
        switches = d;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    // Enter all digits in dq; push each completed operand to the scoreboard.
    task automatic enter_ops(input int ndig);
        logic [15:0] acc;
        acc = 16'h0000;
        for (int i = 0; i < dq.size(); i++) begin
            acc = (acc << 4) | {12'h000, dq[i]};
            pulse_load(dq[i]);
            if ((i % ndig) == ndig - 1) begin
                exp_q.push_back(acc);
                acc = 16'h0000;
            end
        end
    endtask

    // Called right after the final digit edge; ends with the DUT in WAIT_DONE.
    task automatic run_send(input int nops, input bit noisy);
        logic [15:0] e;
        e = 16'hDEAD;
        chk("core_load_strobe", {15'h0, mon_cl}, 16'h1);
        chk("busy_send_load", {15'h0, mon_busy}, 16'h1);
        for (int k = 0; k < nops; k++) begin
            load = noisy && (k == nops - 1);
            tick();
            load = 1'b0;
            if (exp_q.size() == 0) begin
                e = 16'hDEAD;
            end else begin
                e = exp_q.pop_front();
            end
            chk("core_load_single", {15'h0, mon_cl}, 16'h0);
            chk("core_data", mon_cd, e);
        end
        tick();
        chk("busy_wait", {15'h0, mon_busy}, 16'h1);
        chk("shown_wait", {15'h0, mon_shown}, 16'h0);
        chk("core_data_hold", mon_cd, e);
    endtask

    task automatic finish_done();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("shown_on_done", {15'h0, mon_shown}, 16'h1);
        chk("busy_off_done", {15'h0, mon_busy}, 16'h0);
    endtask

    task automatic leave_show();
        pulse_load(4'hF);
        chk("leave_shown", {15'h0, mon_shown}, 16'h0);
        chk("leave_leds", {12'h0, mon_leds}, 16'h0);
        chk("leave_err", {15'h0, mon_err}, 16'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; load = 1'b0; use_b = 1'b0; core_done = 1'b0;
        switches = 4'h0; sel = 2'd0; res_a = 8'h00; res_b = 12'h000;
        tick();
        tick();
        chk("rst_core_load", {14'h0, cl_a, cl_b}, 16'h0);
        chk("rst_core_data_a", {8'h00, cd_a}, 16'h0);
        chk("rst_core_data_b", {4'h0, cd_b}, 16'h0);
        chk("rst_leds", {8'h00, leds_a, leds_b}, 16'h0);
        chk("rst_flags", {10'h0, busy_a, busy_b, shown_a, shown_b, err_a, err_b}, 16'h0);
        reset = 1'b0;
        tick();

        // Basic transaction and result digit selection.
        dq = '{4'h3, 4'h0, 4'h1, 4'h2};
        enter_ops(2);
        run_send(2, 1'b0);
        res_a = 8'h06;
        sel   = 2'd0;
        finish_done();
        chk("t1_leds_sel0", {12'h0, mon_leds}, 16'h6);
        sel = 2'd1;
        tick();
        chk("t1_leds_sel1", {12'h0, mon_leds}, 16'h0);
        res_a = 8'hFF;
        sel   = 2'd0;
        tick();
        chk("t1_result_hold", {12'h0, mon_leds}, 16'h6);
        leave_show();

        // Mid-entry reset, with a simultaneous load that must lose.
        pulse_load(4'h3);
        pulse_load(4'h0);
        reset = 1'b1; load = 1'b1; switches = 4'h7;
        tick();
        reset = 1'b0; load = 1'b0;
        chk("t2_rst_core_data", mon_cd, 16'h0);
        chk("t2_rst_busy", {15'h0, mon_busy}, 16'h0);
        dq = '{4'h1, 4'h2, 4'h4, 4'h8};
        enter_ops(2);
        run_send(2, 1'b0);
        res_a = 8'h12;
        finish_done();
        chk("t2_leds", {12'h0, mon_leds}, 16'h2);
        leave_show();

        // Load pulses while sending and waiting are ignored.
        dq = '{4'h5, 4'h6, 4'h7, 4'h8};
        enter_ops(2);
        run_send(2, 1'b1);
        load = 1'b1; tick(); load = 1'b0; tick();
        load = 1'b1; tick(); load = 1'b0; tick();
        chk("t3_busy_after_noise", {15'h0, mon_busy}, 16'h1);
        chk("t3_shown_after_noise", {15'h0, mon_shown}, 16'h0);
        chk("t3_data_unchanged", mon_cd, 16'h78);
        res_a = 8'h31;
        finish_done();
        chk("t3_leds", {12'h0, mon_leds}, 16'h1);
        leave_show();
        dq = '{4'h9, 4'h1, 4'h2, 4'h3};
        enter_ops(2);
        run_send(2, 1'b0);
        finish_done();
        leave_show();

        // core_done held high long before the transaction reaches WAIT_DONE.
        core_done = 1'b1;
        res_a     = 8'h2A;
        tick();
        tick();
        chk("t6_no_early_show", {15'h0, mon_shown}, 16'h0);
        dq = '{4'h4, 4'h2, 4'h1, 4'h5};
        enter_ops(2);
        run_send(2, 1'b0);
        tick();
        chk("t6_shown_first_wait", {15'h0, mon_shown}, 16'h1);
        chk("t6_leds", {12'h0, mon_leds}, 16'hA);
        core_done = 1'b0;
        res_a     = 8'h77;
        tick();
        chk("t6_latched", {12'h0, mon_leds}, 16'hA);
        leave_show();

        // Watchdog on a core that never answers.
        dq = '{4'h1, 4'h1, 4'h2, 4'h2};
        enter_ops(2);
        run_send(2, 1'b0);
        sel = 2'd1;
`ifdef GCD_WAIT_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        chk("t5_err_not_yet", {14'h0, mon_err, mon_shown}, 16'h0);
        tick();
        chk("t5_err", {15'h0, mon_err}, 16'h1);
        chk("t5_leds_ones", {12'h0, mon_leds}, 16'hF);
        chk("t5_shown", {15'h0, mon_shown}, 16'h1);
`else
        for (int i = 0; i < 40; i++) tick();
        chk("t5_err_tied", {15'h0, mon_err}, 16'h0);
        chk("t5_still_busy", {15'h0, mon_busy}, 16'h1);
        finish_done();
`endif
        leave_show();
        sel = 2'd0;

        // Wide, three-operand instance.
        use_b = 1'b1;
        dq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        enter_ops(3);
        run_send(3, 1'b0);
        res_b = 12'hABC;
        sel   = 2'd2;
        finish_done();
        chk("t4_leds_sel2", {12'h0, mon_leds}, 16'hA);
        sel = 2'd3;
        tick();
        chk("t4_leds_sel3", {12'h0, mon_leds}, 16'h0);
        sel = 2'd0;
        tick();
        chk("t4_leds_sel0", {12'h0, mon_leds}, 16'hC);
        leave_show();
        use_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
